// File: rtl/vga_dac_output_stage.sv
// Two-cycle VGA output stage: 8-bit RGB -> 3-bit resistor DAC, with syncs delayed to match.
// Define DITHER_EN to add a frame-rotated 4x4 Bayer offset ahead of truncation.
module vga_dac_output_stage #(
    parameter int   IN_BITS   = 8,
    parameter int   OUT_BITS  = 3,
    parameter int   POS_BITS  = 10,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_hsync,
    input  logic                i_vsync,
    input  logic                i_visible,
    input  logic [POS_BITS-1:0] i_hpos,
    input  logic [POS_BITS-1:0] i_vpos,
    input  logic [IN_BITS-1:0]  i_r,
    input  logic [IN_BITS-1:0]  i_g,
    input  logic [IN_BITS-1:0]  i_b,
    output logic                o_vga_hsync,
    output logic                o_vga_vsync,
    output logic [OUT_BITS-1:0] o_vga_r,
    output logic [OUT_BITS-1:0] o_vga_g,
    output logic [OUT_BITS-1:0] o_vga_b,
    output logic [1:0]          o_frame
);

    localparam int SHIFT = IN_BITS - OUT_BITS;

    // Add with clamp: a carry out pins the channel at full scale instead of wrapping.
    function automatic logic [IN_BITS-1:0] sat_add(input logic [IN_BITS-1:0] pix,
                                                   input logic [IN_BITS-1:0] off);
        logic [IN_BITS:0] sum;
        sum = {1'b0, pix} + {1'b0, off};
        return sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
    endfunction

`ifdef DITHER_EN
    function automatic logic [IN_BITS-1:0] bayer_offset(input logic [1:0] row,
                                                        input logic [1:0] col);
        logic [3:0] t;
        case ({row, col})
            4'd0:  t = 4'd0;   4'd1:  t = 4'd8;   4'd2:  t = 4'd2;   4'd3:  t = 4'd10;
            4'd4:  t = 4'd12;  4'd5:  t = 4'd4;   4'd6:  t = 4'd14;  4'd7:  t = 4'd6;
            4'd8:  t = 4'd3;   4'd9:  t = 4'd11;  4'd10: t = 4'd1;   4'd11: t = 4'd9;
            4'd12: t = 4'd15;  4'd13: t = 4'd7;   4'd14: t = 4'd13;  default: t = 4'd5;
        endcase
        return {{(IN_BITS-4){1'b0}}, t} << (SHIFT - 4);
    endfunction

    logic [1:0]         dither_row;
    logic [IN_BITS-1:0] offset;

    // Row index advances with the frame so the pattern does not sit still on screen.
    assign dither_row = i_vpos[1:0] + o_frame;
    assign offset     = bayer_offset(dither_row, i_hpos[1:0]);
`else
    logic [IN_BITS-1:0] offset;

    assign offset = '0;
`endif

    logic unused_pos;
    assign unused_pos = ^{i_hpos, i_vpos};

    logic [IN_BITS-1:0] sum_r_p1, sum_g_p1, sum_b_p1;
    logic               vis_p1, hs_p1, vs_p1;
    logic               vs_q;

    // Stage 1: offset and saturate, register alongside visible and syncs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sum_r_p1 <= '0;
            sum_g_p1 <= '0;
            sum_b_p1 <= '0;
            vis_p1   <= 1'b0;
            hs_p1    <= SYNC_IDLE;
            vs_p1    <= SYNC_IDLE;
        end else begin
            sum_r_p1 <= sat_add(i_r, offset);
            sum_g_p1 <= sat_add(i_g, offset);
            sum_b_p1 <= sat_add(i_b, offset);
            vis_p1   <= i_visible;
            hs_p1    <= i_hsync;
            vs_p1    <= i_vsync;
        end
    end

    // Stage 2: truncate to DAC width and blank outside the visible area
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_vga_r     <= '0;
            o_vga_g     <= '0;
            o_vga_b     <= '0;
            o_vga_hsync <= SYNC_IDLE;
            o_vga_vsync <= SYNC_IDLE;
        end else begin
            o_vga_r     <= vis_p1 ? sum_r_p1[IN_BITS-1:SHIFT] : '0;
            o_vga_g     <= vis_p1 ? sum_g_p1[IN_BITS-1:SHIFT] : '0;
            o_vga_b     <= vis_p1 ? sum_b_p1[IN_BITS-1:SHIFT] : '0;
            o_vga_hsync <= hs_p1;
            o_vga_vsync <= vs_p1;
        end
    end

    // Frame counter steps on the vsync assertion edge seen at the input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vs_q    <= SYNC_IDLE;
            o_frame <= 2'd0;
        end else begin
            vs_q <= i_vsync;
            if (vs_q != i_vsync && i_vsync != SYNC_IDLE)
                o_frame <= o_frame + 2'd1;
        end
    end

endmodule

// File: tb/tb_vga_dac_output_stage.sv
// Scoreboard bench for vga_dac_output_stage: driver pushes expected pixels, monitor pops and compares.
module tb_vga_dac_output_stage;

    logic       clk = 1'b0;
    logic       i_reset, i_hsync, i_vsync, i_visible;
    logic [9:0] i_hpos, i_vpos;
    logic [7:0] i_r, i_g, i_b;
    logic       o_vga_hsync, o_vga_vsync;
    logic [2:0] o_vga_r, o_vga_g, o_vga_b;
    logic [1:0] o_frame;

    vga_dac_output_stage dut (
        .i_clk(clk), .i_reset(i_reset), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .i_visible(i_visible), .i_hpos(i_hpos), .i_vpos(i_vpos),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_vga_hsync(o_vga_hsync), .o_vga_vsync(o_vga_vsync),
        .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       hs, vs;
        logic [2:0] r, g, b;
    } pix_t;

    typedef struct {
        int         due;
        logic [1:0] f;
    } frm_t;

    pix_t exq[$];
    frm_t frq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_frame = 0;
    logic m_vsq = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: clamp(channel + offset) / 32, offset from the 4x4 Bayer table when dithering
    function automatic int ref_offset(int hp, int vp, int fr);
`ifdef DITHER_EN
        int bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
        return bay[((vp + fr) % 4) * 4 + (hp % 4)] * 2;
`else
        return 0;
`endif
    endfunction

    function automatic int ref_chan(int c, int off);
        int s;
        s = c + off;
        if (s > 255) s = 255;
        return s / 32;
    endfunction

    task automatic step(input logic rst, input logic hs, input logic vs, input logic vis,
                        input int hp, input int vp, input int r, input int g, input int b);
        pix_t e;
        frm_t f;
        int   off;
        @(negedge clk);
        i_reset = rst; i_hsync = hs; i_vsync = vs; i_visible = vis;
        i_hpos = 10'(hp); i_vpos = 10'(vp);
        i_r = 8'(r); i_g = 8'(g); i_b = 8'(b);
        e.due = cyc + 2;
        if (rst) begin
            e.hs = 1'b1; e.vs = 1'b1; e.r = 3'd0; e.g = 3'd0; e.b = 3'd0;
            foreach (exq[i]) if (exq[i].due == cyc + 1) begin
                exq[i].hs = 1'b1; exq[i].vs = 1'b1;
                exq[i].r = 3'd0; exq[i].g = 3'd0; exq[i].b = 3'd0;
            end
            m_frame = 0;
            m_vsq = 1'b1;
        end else begin
            off = ref_offset(hp, vp, m_frame);
            e.hs = hs; e.vs = vs;
            e.r = vis ? 3'(ref_chan(r, off)) : 3'd0;
            e.g = vis ? 3'(ref_chan(g, off)) : 3'd0;
            e.b = vis ? 3'(ref_chan(b, off)) : 3'd0;
            if (m_vsq != vs && vs != 1'b1) m_frame = (m_frame + 1) % 4;
            m_vsq = vs;
        end
        exq.push_back(e);
        f.due = cyc + 1;
        f.f = 2'(m_frame);
        frq.push_back(f);
    endtask

    // Monitor: every cycle, compare whatever is due against the DUT pins
    always @(posedge clk) begin
        #1;
        while (exq.size() > 0 && exq[0].due <= cyc) begin
            pix_t e;
            e = exq.pop_front();
            total++;
            if (e.due != cyc || o_vga_hsync !== e.hs || o_vga_vsync !== e.vs ||
                o_vga_r !== e.r || o_vga_g !== e.g || o_vga_b !== e.b) begin
                bad++;
                $display("FAIL pixel cyc=%0d due=%0d got hs=%b vs=%b rgb=%0d,%0d,%0d want hs=%b vs=%b rgb=%0d,%0d,%0d",
                         cyc, e.due, o_vga_hsync, o_vga_vsync, o_vga_r, o_vga_g, o_vga_b,
                         e.hs, e.vs, e.r, e.g, e.b);
            end
        end
        while (frq.size() > 0 && frq[0].due <= cyc) begin
            frm_t f;
            f = frq.pop_front();
            total++;
            if (f.due != cyc || o_frame !== f.f) begin
                bad++;
                $display("FAIL frame cyc=%0d got=%0d want=%0d", cyc, o_frame, f.f);
            end
        end
    end

    initial begin
        int wait_cyc;
        i_reset = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_visible = 1'b1;
        i_hpos = '0; i_vpos = '0; i_r = 8'hFF; i_g = 8'hFF; i_b = 8'hFF;

        // Reset held with full-scale colour, then release
        repeat (3) step(1, 1, 1, 1, 0, 0, 255, 255, 255);
        step(0, 1, 1, 1, 5, 5, 255, 255, 255);
        step(0, 1, 1, 1, 6, 5, 100, 200, 40);

        // Single-cycle hsync pulse and 0xE0 red
        step(0, 0, 1, 1, 7, 5, 8'hE0, 0, 0);
        step(0, 1, 1, 1, 8, 5, 8'h1F, 8'h20, 8'h3F);

        // Blanking with full-scale colour
        repeat (4) step(0, 1, 1, 0, 9, 5, 255, 255, 255);

        // Dither row 0, frame 0
        for (int h = 0; h < 4; h++) step(0, 1, 1, 1, h, 0, 8'h10, 8'h10, 8'h10);

        // Saturation at the largest offset
        step(0, 1, 1, 1, 0, 3, 255, 255, 255);
        step(0, 1, 1, 1, 3, 2, 250, 240, 230);

        // Five vsync assertions
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, 0);
            step(0, 1, 1, 0, 0, 0, 0, 0, 0);
            step(0, 1, 1, 1, k, k, 8'h80, 8'h40, 8'hC0);
        end

        // Mid-frame reset with colour still flowing
        step(0, 0, 1, 1, 1, 1, 200, 201, 202);
        step(1, 0, 1, 1, 2, 1, 200, 201, 202);
        step(0, 1, 1, 1, 3, 1, 255, 0, 128);
        step(0, 1, 1, 1, 4, 1, 64, 96, 160);

        // Randomized traffic with sporadic vsync/hsync pulses and resets
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        repeat (3) step(0, 1, 1, 0, 0, 0, 0, 0, 0);

        wait_cyc = 0;
        while ((exq.size() > 0 || frq.size() > 0) && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exq.size() > 0 || frq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exq.size() + frq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
